// File: rtl/dmem_lsu_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of the
// load/store arbiter. The arbiter connects through the slave modport;
// the requesters and the memory connect through the master modport.
interface dmem_lsu_arbiter_if #(
  parameter int N = 9
);

  // Port 0 (core LSU)
  logic          i_p0_req;
  logic          i_p0_we;
  logic [31:0]   i_p0_addr;
  logic [2:0]    i_p0_funct3;
  logic [31:0]   i_p0_wdata;
  logic          o_p0_gnt;
  logic          o_p0_rvalid;
  logic [31:0]   o_p0_rdata;
  logic          o_p0_err;

  // Port 1 (loader / debug)
  logic          i_p1_req;
  logic          i_p1_we;
  logic [31:0]   i_p1_addr;
  logic [2:0]    i_p1_funct3;
  logic [31:0]   i_p1_wdata;
  logic          o_p1_gnt;
  logic          o_p1_rvalid;
  logic [31:0]   o_p1_rdata;
  logic          o_p1_err;

  // Data memory
  logic [N-1:0]  o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [3:0]    o_mem_bmask;
  logic          o_mem_wren;
  logic [31:0]   i_mem_rdata;

  modport slave (
    input  i_p0_req, i_p0_we, i_p0_addr, i_p0_funct3, i_p0_wdata,
    output o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
    input  i_p1_req, i_p1_we, i_p1_addr, i_p1_funct3, i_p1_wdata,
    output o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
    output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren,
    input  i_mem_rdata
  );

  modport master (
    output i_p0_req, i_p0_we, i_p0_addr, i_p0_funct3, i_p0_wdata,
    input  o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
    output i_p1_req, i_p1_we, i_p1_addr, i_p1_funct3, i_p1_wdata,
    input  o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
    input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren,
    output i_mem_rdata
  );

endinterface

// File: rtl/dmem_lsu_arbiter.sv
// Load/store controller in front of a 2^N-word data memory, shared by the
// core LSU (port 0) and the loader/debug path (port 1). One access takes
// three cycles: IDLE (grant + latch), ACCESS (memory cycle), RESP (reply).
// Optional macro LSU_RR_ARB_EN: round-robin arbitration between the ports;
// when undefined, port 0 has fixed priority and port 1 may starve.
module dmem_lsu_arbiter #(
  parameter int N = 9
) (
  input logic               i_clk,
  input logic               i_reset,
  dmem_lsu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         port_q, port_d;
  logic         we_q, we_d;
  logic [31:0]  addr_q, addr_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [31:0]  rdata_q, rdata_d;
`ifdef LSU_RR_ARB_EN
  logic         last_q, last_d;
`endif

  logic         any_req;
  logic         pick1;
  logic         grant;
  logic [1:0]   off;
  logic         misaligned;
  logic         range_err;
  logic         illegal;
  logic         err;
  logic [3:0]   st_bmask;
  logic [31:0]  st_wdata;
  logic [31:0]  ld_shifted;
  logic [31:0]  ld_value;

  // Pick the winning port; a grant is only possible in IDLE and out of reset
  always_comb begin
    any_req = bus.i_p0_req | bus.i_p1_req;
`ifdef LSU_RR_ARB_EN
    pick1 = bus.i_p1_req & (~bus.i_p0_req | ~last_q);
`else
    pick1 = bus.i_p1_req & ~bus.i_p0_req;
`endif
    grant = (state_q == IDLE) & any_req & i_reset;
  end

  // Decode the latched request into error flags, store lanes and load result
  always_comb begin
    off        = addr_q[1:0];
    misaligned = 1'b0;
    case (funct3_q[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    range_err = |addr_q[31:N+2];
    illegal   = (funct3_q == 3'b011) | (funct3_q == 3'b110) |
                (funct3_q == 3'b111) | (funct3_q[2] & we_q);
    err       = misaligned | range_err | illegal;

    st_bmask = 4'b0000;
    st_wdata = 32'h0;
    case (funct3_q[1:0])
      2'b00: begin
        st_bmask = 4'b0001 << off;
        st_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_bmask = 4'b0011 << off;
        st_wdata = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        st_bmask = 4'b1111;
        st_wdata = wdata_q;
      end
      default: begin
        st_bmask = 4'b0000;
        st_wdata = 32'h0;
      end
    endcase

    ld_shifted = bus.i_mem_rdata >> {off, 3'b000};
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b010:  ld_value = ld_shifted;
      3'b100:  ld_value = {24'h0, ld_shifted[7:0]};
      3'b101:  ld_value = {16'h0, ld_shifted[15:0]};
      default: ld_value = 32'h0;
    endcase
  end

  // Next-state logic of the IDLE -> ACCESS -> RESP sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request on grant and capture the load result in ACCESS
  always_comb begin
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef LSU_RR_ARB_EN
    last_d   = last_q;
`endif
    if (grant) begin
      port_d   = pick1;
      we_d     = pick1 ? bus.i_p1_we     : bus.i_p0_we;
      addr_d   = pick1 ? bus.i_p1_addr   : bus.i_p0_addr;
      funct3_d = pick1 ? bus.i_p1_funct3 : bus.i_p0_funct3;
      wdata_d  = pick1 ? bus.i_p1_wdata  : bus.i_p0_wdata;
`ifdef LSU_RR_ARB_EN
      last_d   = pick1;
`endif
    end
    if (state_q == ACCESS) begin
      rdata_d = (~we_q & ~err) ? ld_value : 32'h0;
    end
  end

  // State and request registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
`ifdef LSU_RR_ARB_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef LSU_RR_ARB_EN
      last_q   <= last_d;
`endif
    end
  end

  // Drive grants, the memory cycle and the response from the current state
  always_comb begin
    bus.o_p0_gnt    = grant & ~pick1;
    bus.o_p1_gnt    = grant & pick1;
    bus.o_p0_rvalid = 1'b0;
    bus.o_p0_rdata  = 32'h0;
    bus.o_p0_err    = 1'b0;
    bus.o_p1_rvalid = 1'b0;
    bus.o_p1_rdata  = 32'h0;
    bus.o_p1_err    = 1'b0;
    bus.o_mem_addr  = addr_q[N+1:2];
    bus.o_mem_wdata = 32'h0;
    bus.o_mem_bmask = 4'b0000;
    bus.o_mem_wren  = 1'b0;
    case (state_q)
      ACCESS: begin
        if (we_q & ~err) begin
          bus.o_mem_wren  = 1'b1;
          bus.o_mem_bmask = st_bmask;
          bus.o_mem_wdata = st_wdata;
        end
      end
      RESP: begin
        if (port_q) begin
          bus.o_p1_rvalid = 1'b1;
          bus.o_p1_rdata  = rdata_q;
          bus.o_p1_err    = err;
        end else begin
          bus.o_p0_rvalid = 1'b1;
          bus.o_p0_rdata  = rdata_q;
          bus.o_p0_err    = err;
        end
      end
      default: begin
        bus.o_mem_wren  = 1'b0;
      end
    endcase
  end

endmodule
